// File: rtl/btb_update_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : btb_update_controller_if
// Description : Signal bundle between the BTB update controller, the
//               decode/execute resolve path, fetch and the BTB write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface btb_update_controller_if;
    // Resolved-branch update handshake
    logic        buc_res_valid;
    logic        buc_res_ready;
    logic [31:0] buc_res_pc;
    logic [31:0] buc_res_target;
    logic        buc_res_taken;

    // Fetch coordination and flush control
    logic        buc_lookup_active;
    logic        buc_flush_req;
    logic        buc_flush_busy;
    logic        buc_fetch_hold;

    // BTB write port
    logic        btb_write;
    logic        btb_branch_taken;
    logic [31:0] btb_new_pc;
    logic [31:0] btb_data;

    // Controller side
    modport master (
        input  buc_res_valid, buc_res_pc, buc_res_target, buc_res_taken,
        input  buc_lookup_active, buc_flush_req,
        output buc_res_ready, buc_flush_busy, buc_fetch_hold,
        output btb_write, btb_branch_taken, btb_new_pc, btb_data
    );

    // Environment side (resolve path, fetch, BTB)
    modport slave (
        output buc_res_valid, buc_res_pc, buc_res_target, buc_res_taken,
        output buc_lookup_active, buc_flush_req,
        input  buc_res_ready, buc_flush_busy, buc_fetch_hold,
        input  btb_write, btb_branch_taken, btb_new_pc, btb_data
    );
endinterface
`default_nettype wire

// File: rtl/btb_update_controller.sv
`default_nettype none
// ============================================================================
// Module      : btb_update_controller
// Description : Queues resolved-branch updates and writes them into the BTB
//               in cycles where fetch is not reading it; forces a one-cycle
//               fetch hold when an update starves; runs full-table flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_update_controller #(
    parameter int ENTRIES      = 16,
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         buc_clk,
    input  logic                         buc_reset,
    btb_update_controller_if.master      bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT) + 1;

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [STV_W-1:0] r_starve;
    logic [IDX_W-1:0] r_flush_idx;

    logic [31:0]      r_q_pc    [QDEPTH];
    logic [31:0]      r_q_tgt   [QDEPTH];
    logic             r_q_taken [QDEPTH];

    logic             r_fetch_hold;
    logic             r_btb_write;
    logic             r_btb_taken;
    logic [31:0]      r_btb_pc;
    logic [31:0]      r_btb_data;
    logic             r_flush_wr;     // current BTB write belongs to a flush

    logic             w_full;
    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_flush_start;
    logic             w_starve_inc;
    logic             w_starve_fire;
    logic             w_last_idx;

    // State register
    always_ff @(posedge buc_clk or posedge buc_reset) begin
        if (buc_reset) r_state <= S_RUN;
        else           r_state <= w_state_nxt;
    end

    // Next-state: a flush request in RUN wins over any pop; flush ends after the last index
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (bus.buc_flush_req) w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_last_idx)        w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Control decode and combinational outputs
    always_comb begin
        w_full        = (r_count == CNT_W'(QDEPTH));
        w_ready       = (r_state == S_RUN) && !w_full && !bus.buc_flush_req;
        w_push        = bus.buc_res_valid && w_ready;
        w_flush_start = (r_state == S_RUN) && bus.buc_flush_req;
        w_pop         = (r_state == S_RUN) && !bus.buc_flush_req && (r_count != '0)
                        && (!bus.buc_lookup_active || r_fetch_hold);
        w_starve_inc  = (r_state == S_RUN) && (r_count != '0)
                        && bus.buc_lookup_active && !r_fetch_hold;
        w_starve_fire = w_starve_inc && !bus.buc_flush_req
                        && (r_starve == STV_W'(STARVE_LIMIT - 1));
        w_last_idx    = (r_flush_idx == IDX_W'(ENTRIES - 1));

        bus.buc_res_ready    = w_ready;
        // Busy stays up through the cycle that carries the final flush write
        bus.buc_flush_busy   = (r_state == S_FLUSH) || r_flush_wr;
        bus.buc_fetch_hold   = r_fetch_hold;
        bus.btb_write        = r_btb_write;
        bus.btb_branch_taken = r_btb_taken;
        bus.btb_new_pc       = r_btb_pc;
        bus.btb_data         = r_btb_data;
    end

    // FIFO pointers and occupancy; entering flush discards everything queued
    always_ff @(posedge buc_clk or posedge buc_reset) begin
        if (buc_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // FIFO storage; contents are only meaningful under the occupancy count
    always_ff @(posedge buc_clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]    <= bus.buc_res_pc;
            r_q_tgt[r_wr_ptr]   <= bus.buc_res_target;
            r_q_taken[r_wr_ptr] <= bus.buc_res_taken;
        end
    end

    // Starvation counter: counts consecutive cycles the head is blocked by fetch
    always_ff @(posedge buc_clk or posedge buc_reset) begin
        if (buc_reset)
            r_starve <= '0;
        else if (w_flush_start || w_pop || (r_count == '0))
            r_starve <= '0;
        else if (w_starve_inc)
            r_starve <= r_starve + STV_W'(1);
    end

    // Flush index walks the whole table once per flush
    always_ff @(posedge buc_clk or posedge buc_reset) begin
        if (buc_reset)
            r_flush_idx <= '0;
        else if (w_flush_start)
            r_flush_idx <= '0;
        else if (r_state == S_FLUSH)
            r_flush_idx <= r_flush_idx + IDX_W'(1);
    end

    // Registered BTB write port and fetch hold
    always_ff @(posedge buc_clk or posedge buc_reset) begin
        if (buc_reset) begin
            r_fetch_hold <= 1'b0;
            r_btb_write  <= 1'b0;
            r_btb_taken  <= 1'b0;
            r_btb_pc     <= '0;
            r_btb_data   <= '0;
            r_flush_wr   <= 1'b0;
        end else begin
            r_fetch_hold <= (r_state == S_FLUSH) || w_starve_fire;
            r_btb_write  <= 1'b0;
            r_btb_taken  <= 1'b0;
            r_btb_pc     <= '0;
            r_btb_data   <= '0;
            r_flush_wr   <= 1'b0;
            if (r_state == S_FLUSH) begin
                r_btb_write <= 1'b1;
                r_btb_pc    <= 32'({r_flush_idx, 2'b00});
                r_flush_wr  <= 1'b1;
            end else if (w_pop) begin
                r_btb_write <= 1'b1;
                r_btb_taken <= r_q_taken[r_rd_ptr];
                r_btb_pc    <= r_q_pc[r_rd_ptr];
                r_btb_data  <= r_q_tgt[r_rd_ptr];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btb_update_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_update_controller
// Description : Scoreboard bench for btb_update_controller: stimulus pushes
//               expected BTB writes (with cycle stamps), a negedge monitor
//               retires them against the DUT write port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_update_controller;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] data;
        logic        taken;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    btb_update_controller_if bus ();

    btb_update_controller #(
        .ENTRIES      (16),
        .QDEPTH       (4),
        .STARVE_LIMIT (8)
    ) dut (
        .buc_clk   (clk),
        .buc_reset (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected writes
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: retire scoreboard entries against the BTB write port
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                n_vec++;
                n_miss++;
                $display("FAIL missing_write at cyc=%0d: actual none, required pc=%h data=%h taken=%b",
                         e.cyc, e.pc, e.data, e.taken);
            end
            n_vec++;
            if (bus.btb_write) begin
                if (q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_write cyc=%0d: actual pc=%h data=%h taken=%b, required no write",
                             cyc, bus.btb_new_pc, bus.btb_data, bus.btb_branch_taken);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.pc != bus.btb_new_pc || e.data != bus.btb_data
                        || e.taken != bus.btb_branch_taken) begin
                        n_miss++;
                        $display("FAIL btb_write: actual cyc=%0d pc=%h data=%h taken=%b, required cyc=%0d pc=%h data=%h taken=%b",
                                 cyc, bus.btb_new_pc, bus.btb_data, bus.btb_branch_taken,
                                 e.cyc, e.pc, e.data, e.taken);
                    end
                end
            end else if (bus.btb_new_pc != 0 || bus.btb_data != 0 || bus.btb_branch_taken != 0) begin
                n_miss++;
                $display("FAIL idle_outputs cyc=%0d: actual pc=%h data=%h taken=%b, required all zero",
                         cyc, bus.btb_new_pc, bus.btb_data, bus.btb_branch_taken);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s cyc=%0d: actual %h, required %h", name, cyc, act, exp);
        end
    endtask

    // Move to just after the next rising edge (safe point to drive inputs)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge of cycle n (safe point to sample outputs)
    task automatic goto(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    // Offer one update; returns the edge index at which it was accepted
    task automatic push_upd(input logic [31:0] pc, input logic [31:0] tgt,
                            input logic tk, output int acc);
        bus.buc_res_valid  = 1'b1;
        bus.buc_res_pc     = pc;
        bus.buc_res_target = tgt;
        bus.buc_res_taken  = tk;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.buc_res_ready) begin
                step();
                acc = cyc;
                break;
            end
            step();
        end
        bus.buc_res_valid = 1'b0;
        if (acc < 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL push_timeout: actual not accepted, required accepted pc=%h", pc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual still running, required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a3, s, s2, f, e;

        bus.buc_res_valid     = 1'b0;
        bus.buc_res_pc        = '0;
        bus.buc_res_target    = '0;
        bus.buc_res_taken     = 1'b0;
        bus.buc_lookup_active = 1'b0;
        bus.buc_flush_req     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_write", 32'(bus.btb_write), 32'd0);
        chk("reset_hold",  32'(bus.buc_fetch_hold), 32'd0);
        chk("reset_busy",  32'(bus.buc_flush_busy), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        step();
        chk("reset_ready", 32'(bus.buc_res_ready), 32'd1);

        // 1: idle write, minimum latency
        push_upd(32'h100, 32'h200, 1'b1, a);
        q.push_back('{a + 1, 32'h100, 32'h200, 1'b1});
        goto(a + 4);

        // 2: fill with fetch busy, 5th held off, then drain in order
        step();
        bus.buc_lookup_active = 1'b1;
        push_upd(32'h1000, 32'h2000, 1'b1, a);
        push_upd(32'h1004, 32'h2004, 1'b0, a);
        push_upd(32'h1008, 32'h2008, 1'b1, a);
        push_upd(32'h100C, 32'h200C, 1'b1, a3);
        bus.buc_res_valid  = 1'b1;
        bus.buc_res_pc     = 32'h1010;
        bus.buc_res_target = 32'h2010;
        bus.buc_res_taken  = 1'b1;
        @(negedge clk);
        chk("t2_full_ready", 32'(bus.buc_res_ready), 32'd0);
        step();
        bus.buc_res_valid     = 1'b0;
        bus.buc_lookup_active = 1'b0;
        q.push_back('{a3 + 2, 32'h1000, 32'h2000, 1'b1});
        q.push_back('{a3 + 3, 32'h1004, 32'h2004, 1'b0});
        q.push_back('{a3 + 4, 32'h1008, 32'h2008, 1'b1});
        q.push_back('{a3 + 5, 32'h100C, 32'h200C, 1'b1});
        goto(a3 + 9);
        chk("t2_ready_after", 32'(bus.buc_res_ready), 32'd1);

        // 3: starvation forces a single hold cycle, counter rearms
        step();
        bus.buc_lookup_active = 1'b1;
        push_upd(32'h300, 32'h400, 1'b0, s);
        q.push_back('{s + 9, 32'h300, 32'h400, 1'b0});
        goto(s + 7);
        chk("t3_hold_before", 32'(bus.buc_fetch_hold), 32'd0);
        goto(s + 8);
        chk("t3_hold_pulse", 32'(bus.buc_fetch_hold), 32'd1);
        goto(s + 9);
        chk("t3_hold_after", 32'(bus.buc_fetch_hold), 32'd0);
        step();
        push_upd(32'h304, 32'h404, 1'b1, s2);
        q.push_back('{s2 + 9, 32'h304, 32'h404, 1'b1});
        goto(s2 + 7);
        chk("t3b_hold_before", 32'(bus.buc_fetch_hold), 32'd0);
        goto(s2 + 8);
        chk("t3b_hold_pulse", 32'(bus.buc_fetch_hold), 32'd1);
        goto(s2 + 10);

        // 4: flush discards queued updates and invalidates every entry
        step();
        push_upd(32'h500, 32'h600, 1'b1, f);
        push_upd(32'h504, 32'h604, 1'b1, f);
        push_upd(32'h508, 32'h608, 1'b1, f);
        bus.buc_flush_req = 1'b1;
        @(negedge clk);
        chk("t4_req_ready", 32'(bus.buc_res_ready), 32'd0);
        step();
        e = cyc;
        bus.buc_flush_req = 1'b0;
        for (int k = 0; k < 16; k++) q.push_back('{e + 1 + k, 32'(k * 4), 32'h0, 1'b0});
        goto(e);
        chk("t4_busy_entry", 32'(bus.buc_flush_busy), 32'd1);
        chk("t4_hold_entry", 32'(bus.buc_fetch_hold), 32'd0);
        goto(e + 1);
        chk("t4_hold_first", 32'(bus.buc_fetch_hold), 32'd1);
        goto(e + 8);
        chk("t4_ready_mid", 32'(bus.buc_res_ready), 32'd0);
        goto(e + 16);
        chk("t4_busy_last", 32'(bus.buc_flush_busy), 32'd1);
        chk("t4_hold_last", 32'(bus.buc_fetch_hold), 32'd1);
        goto(e + 17);
        chk("t4_busy_done", 32'(bus.buc_flush_busy), 32'd0);
        chk("t4_hold_done", 32'(bus.buc_fetch_hold), 32'd0);
        chk("t4_ready_done", 32'(bus.buc_res_ready), 32'd1);

        // 5: update offered in the same cycle as a flush request is refused
        step();
        bus.buc_lookup_active = 1'b0;
        bus.buc_res_valid     = 1'b1;
        bus.buc_res_pc        = 32'h700;
        bus.buc_res_target    = 32'h800;
        bus.buc_res_taken     = 1'b1;
        bus.buc_flush_req     = 1'b1;
        @(negedge clk);
        chk("t5_ready", 32'(bus.buc_res_ready), 32'd0);
        step();
        e = cyc;
        bus.buc_res_valid = 1'b0;
        bus.buc_flush_req = 1'b0;
        for (int k = 0; k < 16; k++) q.push_back('{e + 1 + k, 32'(k * 4), 32'h0, 1'b0});
        goto(e);
        chk("t5_busy", 32'(bus.buc_flush_busy), 32'd1);
        goto(e + 18);

        // 6: reset while flush_idx=5 aborts the flush
        step();
        bus.buc_flush_req = 1'b1;
        step();
        e = cyc;
        bus.buc_flush_req = 1'b0;
        for (int k = 0; k < 5; k++) q.push_back('{e + 1 + k, 32'(k * 4), 32'h0, 1'b0});
        goto(e + 5);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_write", 32'(bus.btb_write), 32'd0);
        chk("t6_rst_pc",    bus.btb_new_pc, 32'd0);
        chk("t6_rst_busy",  32'(bus.buc_flush_busy), 32'd0);
        chk("t6_rst_hold",  32'(bus.buc_fetch_hold), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        goto(e + 7);
        chk("t6_ready", 32'(bus.buc_res_ready), 32'd1);
        chk("t6_busy",  32'(bus.buc_flush_busy), 32'd0);
        goto(e + 25);

        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
